// File: rtl/handshake_source_if.sv
// handshake_source_if: single-beat valid/ready channel.
//   s_d_valid : source -> sink, payload valid
//   s_d_ready : sink -> source, sink can accept
//   s_d_data  : source -> sink, payload (DW bits)
// master modport is the source side, slave modport is the sink side.
interface handshake_source_if #(
  parameter int DW = 8
) ();
  logic          s_d_valid;
  logic          s_d_ready;
  logic [DW-1:0] s_d_data;

  modport master (output s_d_valid, output s_d_data, input s_d_ready);
  modport slave  (input s_d_valid, input s_d_data, output s_d_ready);
endinterface

// File: rtl/handshake_source.sv
// handshake_source: valid/ready traffic generator.
// Emits cfg_bursts bursts of cfg_len beats, with cfg_gap idle cycles between
// bursts. The payload is an incrementing sequence starting at cfg_base and
// continues across bursts.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               run request, only honoured in IDLE
//   cfg_base/len/gap/bursts  run configuration, latched when start is accepted
//   s_d (master)        outgoing handshake channel
//   busy                run in progress (SEND/GAP)
//   done                one-cycle pulse when the run ends
//   beat_cnt/stall_cnt  saturating counts of accepted beats / stalled cycles
// Every output is a flop; s_d_ready only feeds next-state logic.
module handshake_source #(
  parameter int DW = 8,
  parameter int LW = 8,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DW-1:0]          cfg_base,
  input  logic [LW-1:0]          cfg_len,
  input  logic [LW-1:0]          cfg_gap,
  input  logic [LW-1:0]          cfg_bursts,
  handshake_source_if.master     s_d,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          beat_cnt,
  output logic [CW-1:0]          stall_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  typedef struct packed {
    logic [LW-1:0] len;
    logic [LW-1:0] gap;
    logic [LW-1:0] bursts;
  } cfg_t;

  state_t        state_q,     state_n;
  cfg_t          cfg_q,       cfg_n;
  logic [LW-1:0] beat_q,      beat_n;      // beat index inside current burst
  logic [LW-1:0] burst_q,     burst_n;     // burst index inside the run
  logic [LW-1:0] gap_q,       gap_n;       // idle cycles spent in GAP
  logic          valid_q,     valid_n;
  logic [DW-1:0] data_q,      data_n;
  logic          busy_q,      busy_n;
  logic          done_q,      done_n;
  logic [CW-1:0] beat_cnt_q,  beat_cnt_n;
  logic [CW-1:0] stall_cnt_q, stall_cnt_n;

  logic last_beat, last_burst;
  assign last_beat  = (beat_q  == cfg_q.len    - 1'b1);
  assign last_burst = (burst_q == cfg_q.bursts - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      beat_q      <= '0;
      burst_q     <= '0;
      gap_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      cfg_q       <= cfg_n;
      beat_q      <= beat_n;
      burst_q     <= burst_n;
      gap_q       <= gap_n;
      valid_q     <= valid_n;
      data_q      <= data_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      beat_cnt_q  <= beat_cnt_n;
      stall_cnt_q <= stall_cnt_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cfg_n       = cfg_q;
    beat_n      = beat_q;
    burst_n     = burst_q;
    gap_n       = gap_q;
    valid_n     = valid_q;
    data_n      = data_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    beat_cnt_n  = beat_cnt_q;
    stall_cnt_n = stall_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          beat_cnt_n  = '0;
          stall_cnt_n = '0;
          if (cfg_len != '0 && cfg_bursts != '0) begin
            cfg_n   = '{len: cfg_len, gap: cfg_gap, bursts: cfg_bursts};
            beat_n  = '0;
            burst_n = '0;
            data_n  = cfg_base;
            valid_n = 1'b1;
            busy_n  = 1'b1;
            state_n = SEND;
          end else begin
            // Empty run: report completion without sending anything.
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = FIN;
          end
        end
      end

      SEND: begin
        if (valid_q && s_d.s_d_ready) begin
          if (beat_cnt_q != {CW{1'b1}}) beat_cnt_n = beat_cnt_q + 1'b1;
          data_n = data_q + 1'b1;
          if (!last_beat) begin
            beat_n = beat_q + 1'b1;
          end else begin
            beat_n = '0;
            if (last_burst) begin
              valid_n = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = FIN;
            end else begin
              burst_n = burst_q + 1'b1;
              // Zero gap keeps valid up so bursts run back-to-back.
              if (cfg_q.gap != '0) begin
                valid_n = 1'b0;
                gap_n   = '0;
                state_n = GAP;
              end
            end
          end
        end else if (valid_q) begin
          if (stall_cnt_q != {CW{1'b1}}) stall_cnt_n = stall_cnt_q + 1'b1;
        end
      end

      GAP: begin
        // Valid re-rises on the edge that closes the cfg_gap-th idle cycle.
        if (gap_q == cfg_q.gap - 1'b1) begin
          valid_n = 1'b1;
          state_n = SEND;
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end

      FIN: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign s_d.s_d_valid = valid_q;
  assign s_d.s_d_data  = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_cnt      = beat_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_handshake_source.sv
// Directed bench for handshake_source. Counters are narrowed to 4 bits so
// saturation is reachable in a few dozen cycles. Inputs change and outputs
// are sampled on the falling edge.
module tb_handshake_source;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] cfg_base;
  logic [LW-1:0] cfg_len, cfg_gap, cfg_bursts;
  logic          busy, done;
  logic [CW-1:0] beat_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  handshake_source_if #(.DW(DW)) sif ();

  handshake_source #(.DW(DW), .LW(LW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_len   (cfg_len),
    .cfg_gap   (cfg_gap),
    .cfg_bursts(cfg_bursts),
    .s_d       (sif.master),
    .busy      (busy),
    .done      (done),
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic do_start(input logic [7:0] base, input logic [7:0] len,
                          input logic [7:0] gap, input logic [7:0] bursts);
    cfg_base = base; cfg_len = len; cfg_gap = gap; cfg_bursts = bursts;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] act;
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_gap = '0;
    cfg_bursts = '0; sif.s_d_ready = 1'b0;
    repeat (2) @(negedge clk);
    act = {sif.s_d_valid, sif.s_d_data, busy, done, beat_cnt, stall_cnt};
    total++;
    if (act !== 19'h0) begin
      bad++; $display("FAIL reset_state got %h want %h", act, 19'h0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    logic [10:0] act, exp;
    logic [10:0] fin_act;
    sif.s_d_ready = 1'b1;
    do_start(8'h10, 8'd4, 8'd0, 8'd1);
    for (int i = 0; i < 4; i++) begin
      act = {sif.s_d_valid, sif.s_d_data, busy, done};
      exp = {1'b1, 8'h10 + 8'(i), 1'b1, 1'b0};
      total++;
      if (act !== exp) begin
        bad++; $display("FAIL single_beat%0d got %h want %h", i, act, exp);
      end
      @(negedge clk);
    end
    fin_act = {sif.s_d_valid, busy, done, beat_cnt, stall_cnt};
    total++;
    if (fin_act !== {1'b0, 1'b0, 1'b1, 4'd4, 4'd0}) begin
      bad++; $display("FAIL single_done got %h want %h", fin_act, {1'b0, 1'b0, 1'b1, 4'd4, 4'd0});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL single_done_pulse got %b want 0", done);
    end
    // Earliest restart: start presented in the cycle right after done.
    do_start(8'h40, 8'd1, 8'd0, 8'd1);
    act = {sif.s_d_valid, sif.s_d_data, busy, done};
    total++;
    if (act !== {1'b1, 8'h40, 1'b1, 1'b0}) begin
      bad++; $display("FAIL restart_first got %h want %h", act, {1'b1, 8'h40, 1'b1, 1'b0});
    end
    @(negedge clk);
    total++;
    if ({done, beat_cnt} !== {1'b1, 4'd1}) begin
      bad++; $display("FAIL restart_done got %h want %h", {done, beat_cnt}, {1'b1, 4'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [8:0] act, exp;
    sif.s_d_ready = 1'b0;
    do_start(8'h10, 8'd3, 8'd0, 8'd1);
    for (int i = 0; i < 4; i++) begin
      act = {sif.s_d_valid, sif.s_d_data};
      total++;
      if (act !== {1'b1, 8'h10}) begin
        bad++; $display("FAIL bp_hold%0d got %h want %h", i, act, {1'b1, 8'h10});
      end
      if (i == 3) sif.s_d_ready = 1'b1;
      @(negedge clk);
    end
    for (int i = 1; i < 3; i++) begin
      act = {sif.s_d_valid, sif.s_d_data};
      exp = {1'b1, 8'h10 + 8'(i)};
      total++;
      if (act !== exp) begin
        bad++; $display("FAIL bp_beat%0d got %h want %h", i, act, exp);
      end
      @(negedge clk);
    end
    total++;
    if ({sif.s_d_valid, done, beat_cnt, stall_cnt} !== {1'b0, 1'b1, 4'd3, 4'd3}) begin
      bad++; $display("FAIL bp_done got %h want %h",
                      {sif.s_d_valid, done, beat_cnt, stall_cnt}, {1'b0, 1'b1, 4'd3, 4'd3});
    end
    @(negedge clk);
  endtask

  task automatic test_gap_wrap();
    logic [9:0] exp_tr [0:8];
    logic [9:0] act;
    // {valid, done, data}; data compared only while valid is expected high.
    exp_tr = '{{2'b10, 8'hFE}, {2'b10, 8'hFF}, {2'b00, 8'h00}, {2'b00, 8'h00},
               {2'b00, 8'h00}, {2'b10, 8'h00}, {2'b10, 8'h01}, {2'b01, 8'h00},
               {2'b00, 8'h00}};
    sif.s_d_ready = 1'b1;
    do_start(8'hFE, 8'd2, 8'd3, 8'd2);
    for (int i = 0; i < 9; i++) begin
      act = {sif.s_d_valid, done, exp_tr[i][9] ? sif.s_d_data : 8'h00};
      total++;
      if (act !== exp_tr[i]) begin
        bad++; $display("FAIL gap_cycle%0d got %h want %h", i, act, exp_tr[i]);
      end
      if (i == 7) begin
        total++;
        if (beat_cnt !== 4'd4) begin
          bad++; $display("FAIL gap_beat_cnt got %0d want 4", beat_cnt);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    logic [8:0] act, exp;
    sif.s_d_ready = 1'b1;
    do_start(8'h20, 8'd4, 8'd0, 8'd2);
    for (int i = 0; i < 8; i++) begin
      act = {sif.s_d_valid, sif.s_d_data};
      exp = {1'b1, 8'h20 + 8'(i)};
      total++;
      if (act !== exp) begin
        bad++; $display("FAIL ign_beat%0d got %h want %h", i, act, exp);
      end
      if (i == 2) begin
        start = 1'b1; cfg_base = 8'h80; cfg_len = 8'd8; cfg_bursts = 8'd1;
      end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    total++;
    if ({sif.s_d_valid, done, beat_cnt} !== {1'b0, 1'b1, 4'd8}) begin
      bad++; $display("FAIL ign_done got %h want %h", {sif.s_d_valid, done, beat_cnt}, {1'b0, 1'b1, 4'd8});
    end
    start = 1'b1;  // arrives during FIN
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({sif.s_d_valid, busy, done} !== 3'b000) begin
        bad++; $display("FAIL ign_no_restart%0d got %b want 000", i, {sif.s_d_valid, busy, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_len();
    logic [10:0] act;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) do_start(8'h33, 8'd0, 8'd2, 8'd3);
      else        do_start(8'h33, 8'd4, 8'd0, 8'd0);
      act = {sif.s_d_valid, busy, done, beat_cnt, stall_cnt};
      total++;
      if (act !== {1'b0, 1'b0, 1'b1, 4'd0, 4'd0}) begin
        bad++; $display("FAIL zero%0d_done got %h want %h", k, act, {1'b0, 1'b0, 1'b1, 4'd0, 4'd0});
      end
      @(negedge clk);
      total++;
      if ({sif.s_d_valid, done} !== 2'b00) begin
        bad++; $display("FAIL zero%0d_after got %b want 00", k, {sif.s_d_valid, done});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [18:0] act;
    sif.s_d_ready = 1'b0;
    do_start(8'h50, 8'd4, 8'd0, 8'd1);
    total++;
    if ({sif.s_d_valid, sif.s_d_data} !== {1'b1, 8'h50}) begin
      bad++; $display("FAIL mrst_first got %h want %h", {sif.s_d_valid, sif.s_d_data}, {1'b1, 8'h50});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    act = {sif.s_d_valid, sif.s_d_data, busy, done, beat_cnt, stall_cnt};
    total++;
    if (act !== 19'h0) begin
      bad++; $display("FAIL mrst_state got %h want %h", act, 19'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({sif.s_d_valid, done} !== 2'b00) begin
      bad++; $display("FAIL mrst_no_done got %b want 00", {sif.s_d_valid, done});
    end
    sif.s_d_ready = 1'b1;
    do_start(8'h05, 8'd1, 8'd0, 8'd1);
    total++;
    if ({sif.s_d_valid, sif.s_d_data, busy} !== {1'b1, 8'h05, 1'b1}) begin
      bad++; $display("FAIL mrst_rerun got %h want %h", {sif.s_d_valid, sif.s_d_data, busy}, {1'b1, 8'h05, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({done, beat_cnt, stall_cnt} !== {1'b1, 4'd1, 4'd0}) begin
      bad++; $display("FAIL mrst_rerun_done got %h want %h", {done, beat_cnt, stall_cnt}, {1'b1, 4'd1, 4'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    sif.s_d_ready = 1'b1;
    do_start(8'h00, 8'd20, 8'd0, 8'd1);
    repeat (20) @(negedge clk);
    total++;
    if ({done, beat_cnt} !== {1'b1, 4'd15}) begin
      bad++; $display("FAIL sat_beat got %h want %h", {done, beat_cnt}, {1'b1, 4'd15});
    end
    @(negedge clk);
    sif.s_d_ready = 1'b0;
    do_start(8'h00, 8'd1, 8'd0, 8'd1);
    repeat (20) @(negedge clk);
    total++;
    if ({sif.s_d_valid, stall_cnt} !== {1'b1, 4'd15}) begin
      bad++; $display("FAIL sat_stall got %h want %h", {sif.s_d_valid, stall_cnt}, {1'b1, 4'd15});
    end
    sif.s_d_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({done, beat_cnt, stall_cnt} !== {1'b1, 4'd1, 4'd15}) begin
      bad++; $display("FAIL sat_stall_done got %h want %h", {done, beat_cnt, stall_cnt}, {1'b1, 4'd1, 4'd15});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_gap_wrap();
    test_ignored_start();
    test_zero_len();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
